// File: rtl/sys_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sys_ctrl: UART command parser driving register file, ALU and TX path |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module sys_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int ALU_OUT_WIDTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]    RdData,
  input  logic                     RdData_valid,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     ALU_OUT_VLD,
  input  logic                     TX_BUSY,
  output logic [ADDRESS_WIDTH-1:0] Address,
  output logic                     WrEn,
  output logic                     RdEn,
  output logic [DATA_WIDTH-1:0]    WrData,
  output logic                     ALU_EN,
  output logic [3:0]               ALU_FUN,
  output logic                     CLK_EN,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD
);

  localparam logic [DATA_WIDTH-1:0] c_OP_WRITE   = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] c_OP_READ    = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] c_OP_ALU_OPS = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] c_OP_ALU_FUN = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_WR_ADDR    = 4'd1,
    S_WR_DATA    = 4'd2,
    S_RD_ADDR    = 4'd3,
    S_RD_WAIT    = 4'd4,
    S_ALU_A      = 4'd5,
    S_ALU_B      = 4'd6,
    S_ALU_FUN    = 4'd7,
    S_ALU_WAIT   = 4'd8,
    S_TX_SEND    = 4'd9,
    S_TX_GAP     = 4'd10,
    S_TX_SEND_HI = 4'd11
  } state_t;

  state_t                   r_state, w_state;
  logic [ADDRESS_WIDTH-1:0] r_wr_addr, w_wr_addr;
  logic [DATA_WIDTH-1:0]    r_tx_lo, w_tx_lo;
  logic [DATA_WIDTH-1:0]    r_tx_hi, w_tx_hi;
  logic                     r_two_bytes, w_two_bytes;

  logic [ADDRESS_WIDTH-1:0] r_address, w_address;
  logic [DATA_WIDTH-1:0]    r_wr_data, w_wr_data;
  logic [DATA_WIDTH-1:0]    r_tx_data, w_tx_data;
  logic [3:0]               r_alu_fun, w_alu_fun;
  logic                     r_wr_en, w_wr_en;
  logic                     r_rd_en, w_rd_en;
  logic                     r_alu_en, w_alu_en;
  logic                     r_clk_en, w_clk_en;
  logic                     r_tx_vld, w_tx_vld;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_wr_addr   = r_wr_addr;
    w_tx_lo     = r_tx_lo;
    w_tx_hi     = r_tx_hi;
    w_two_bytes = r_two_bytes;
    w_address   = r_address;
    w_wr_data   = r_wr_data;
    w_tx_data   = r_tx_data;
    w_alu_fun   = r_alu_fun;
    w_clk_en    = r_clk_en;
    w_wr_en     = 1'b0;
    w_rd_en     = 1'b0;
    w_alu_en    = 1'b0;
    w_tx_vld    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (RX_D_VLD) begin
          case (RX_P_DATA)
            c_OP_WRITE:   w_state = S_WR_ADDR;
            c_OP_READ:    w_state = S_RD_ADDR;
            c_OP_ALU_OPS: w_state = S_ALU_A;
            c_OP_ALU_FUN: w_state = S_ALU_FUN;
            default:      w_state = S_IDLE;
          endcase
        end
      end
      S_WR_ADDR: begin
        if (RX_D_VLD) begin
          w_wr_addr = RX_P_DATA[ADDRESS_WIDTH-1:0];
          w_state   = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        if (RX_D_VLD) begin
          w_wr_en   = 1'b1;
          w_address = r_wr_addr;
          w_wr_data = RX_P_DATA;
          w_state   = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (RX_D_VLD) begin
          w_rd_en   = 1'b1;
          w_address = RX_P_DATA[ADDRESS_WIDTH-1:0];
          w_state   = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (RdData_valid) begin
          w_tx_lo     = RdData;
          w_two_bytes = 1'b0;
          w_state     = S_TX_SEND;
        end
      end
      // Operands land in fixed ALU operand registers 0 and 1
      S_ALU_A: begin
        if (RX_D_VLD) begin
          w_wr_en   = 1'b1;
          w_address = ADDRESS_WIDTH'(0);
          w_wr_data = RX_P_DATA;
          w_state   = S_ALU_B;
        end
      end
      S_ALU_B: begin
        if (RX_D_VLD) begin
          w_wr_en   = 1'b1;
          w_address = ADDRESS_WIDTH'(1);
          w_wr_data = RX_P_DATA;
          w_state   = S_ALU_FUN;
        end
      end
      S_ALU_FUN: begin
        if (RX_D_VLD) begin
          w_alu_fun = RX_P_DATA[3:0];
          w_alu_en  = 1'b1;
          w_clk_en  = 1'b1;
          w_state   = S_ALU_WAIT;
        end
      end
      S_ALU_WAIT: begin
        if (ALU_OUT_VLD) begin
          w_clk_en    = 1'b0;
          w_tx_lo     = ALU_OUT[DATA_WIDTH-1:0];
          w_tx_hi     = ALU_OUT[ALU_OUT_WIDTH-1:DATA_WIDTH];
          w_two_bytes = 1'b1;
          w_state     = S_TX_SEND;
        end
      end
      S_TX_SEND: begin
        if (!TX_BUSY) begin
          w_tx_vld  = 1'b1;
          w_tx_data = r_tx_lo;
          w_state   = r_two_bytes ? S_TX_GAP : S_IDLE;
        end
      end
      // Busy must be seen high first, or the high byte could race the low one
      S_TX_GAP: begin
        if (TX_BUSY) begin
          w_state = S_TX_SEND_HI;
        end
      end
      S_TX_SEND_HI: begin
        if (!TX_BUSY) begin
          w_tx_vld  = 1'b1;
          w_tx_data = r_tx_hi;
          w_state   = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_addr   <= '0;
      r_tx_lo     <= '0;
      r_tx_hi     <= '0;
      r_two_bytes <= 1'b0;
      r_address   <= '0;
      r_wr_data   <= '0;
      r_tx_data   <= '0;
      r_alu_fun   <= '0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_alu_en    <= 1'b0;
      r_clk_en    <= 1'b0;
      r_tx_vld    <= 1'b0;
    end else begin
      r_wr_addr   <= w_wr_addr;
      r_tx_lo     <= w_tx_lo;
      r_tx_hi     <= w_tx_hi;
      r_two_bytes <= w_two_bytes;
      r_address   <= w_address;
      r_wr_data   <= w_wr_data;
      r_tx_data   <= w_tx_data;
      r_alu_fun   <= w_alu_fun;
      r_wr_en     <= w_wr_en;
      r_rd_en     <= w_rd_en;
      r_alu_en    <= w_alu_en;
      r_clk_en    <= w_clk_en;
      r_tx_vld    <= w_tx_vld;
    end
  end

  assign Address   = r_address;
  assign WrEn      = r_wr_en;
  assign RdEn      = r_rd_en;
  assign WrData    = r_wr_data;
  assign ALU_EN    = r_alu_en;
  assign ALU_FUN   = r_alu_fun;
  assign CLK_EN    = r_clk_en;
  assign TX_P_DATA = r_tx_data;
  assign TX_D_VLD  = r_tx_vld;

endmodule
`default_nettype wire

// File: tb/tb_sys_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sys_ctrl: frame-level bench with register/ALU/UART responders     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_sys_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [7:0]  RdData;
  logic        RdData_valid;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic        TX_BUSY;
  logic [3:0]  Address;
  logic        WrEn;
  logic        RdEn;
  logic [7:0]  WrData;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic        CLK_EN;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;

  sys_ctrl #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4), .ALU_OUT_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_valid(RdData_valid),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .TX_BUSY(TX_BUSY),
    .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Observed transactions and responder settings
  logic [11:0] wr_q[$];
  logic [3:0]  rd_q[$];
  logic [3:0]  alu_q[$];
  logic [7:0]  tx_q[$];
  int          tx_cyc_q[$];
  logic [7:0]  rd_val = 8'h00;
  logic [15:0] alu_val = 16'h0000;
  int          busy_len = 3;
  int          alu_lat = 2;
  int          cyc = 0;
  int          last_rx_cyc = -10;
  int          busy_cnt = 0;
  int          alu_cnt = 0;
  int          n_strobe;

  // Monitor then respond, once per falling edge
  initial begin
    RdData = 8'h00; RdData_valid = 1'b0;
    ALU_OUT = 16'h0000; ALU_OUT_VLD = 1'b0; TX_BUSY = 1'b0;
    forever begin
      @(negedge CLK);
      cyc++;
      n_strobe = int'(WrEn) + int'(RdEn) + int'(ALU_EN) + int'(TX_D_VLD);
      if (n_strobe > 0) check("strobe_overlap", n_strobe, 1);
      if (WrEn) begin
        check("wr_latency", cyc - last_rx_cyc, 1);
        wr_q.push_back({Address, WrData});
      end
      if (RdEn) begin
        check("rd_latency", cyc - last_rx_cyc, 1);
        rd_q.push_back(Address);
      end
      if (ALU_EN) begin
        check("alu_latency", cyc - last_rx_cyc, 1);
        check("clk_en_at_alu_en", CLK_EN, 1);
        alu_q.push_back(ALU_FUN);
      end
      if (ALU_OUT_VLD) check("clk_en_after_result", CLK_EN, 0);
      if (TX_D_VLD) begin
        check("tx_while_busy", TX_BUSY, 0);
        tx_q.push_back(TX_P_DATA);
        tx_cyc_q.push_back(cyc);
      end
      if (RX_D_VLD) last_rx_cyc = cyc;

      RdData_valid = 1'b0;
      ALU_OUT_VLD  = 1'b0;
      if (RdEn) begin
        RdData = rd_val;
        RdData_valid = 1'b1;
      end
      if (alu_cnt > 0) begin
        alu_cnt--;
        if (alu_cnt == 0) begin
          ALU_OUT = alu_val;
          ALU_OUT_VLD = 1'b1;
        end
      end
      if (ALU_EN) alu_cnt = alu_lat;
      if (busy_cnt > 0) busy_cnt--;
      if (TX_D_VLD) busy_cnt = busy_len;
      if (!RST) begin
        alu_cnt = 0;
        busy_cnt = 0;
      end
      TX_BUSY = (busy_cnt > 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  function automatic int frame_len(input logic [7:0] op);
    case (op)
      8'hAA:   return 3;
      8'hBB:   return 2;
      8'hCC:   return 4;
      8'hDD:   return 2;
      default: return 1;
    endcase
  endfunction

  // Reference: what a frame must cause, straight from the command rules
  task automatic model(input logic [31:0] b, input logic [7:0] rd, input logic [15:0] alu,
                       output int nwr, output logic [23:0] wr, output int nrd, output logic [3:0] ra,
                       output int nalu, output logic [3:0] fun, output int ntx, output logic [15:0] tx);
    nwr = 0; wr = '0; nrd = 0; ra = '0; nalu = 0; fun = '0; ntx = 0; tx = '0;
    case (b[31:24])
      8'hAA: begin nwr = 1; wr = {b[19:16], b[15:8], 12'h000}; end
      8'hBB: begin nrd = 1; ra = b[19:16]; ntx = 1; tx = {rd, 8'h00}; end
      8'hCC: begin
        nwr = 2; wr = {4'h0, b[23:16], 4'h1, b[15:8]};
        nalu = 1; fun = b[3:0]; ntx = 2; tx = {alu[7:0], alu[15:8]};
      end
      8'hDD: begin nalu = 1; fun = b[19:16]; ntx = 2; tx = {alu[7:0], alu[15:8]}; end
      default: ;
    endcase
  endtask

  task automatic clear_q();
    wr_q.delete(); rd_q.delete(); alu_q.delete(); tx_q.delete(); tx_cyc_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge CLK); #2;
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(posedge CLK); #2;
    RX_D_VLD  = 1'b0;
    repeat (gap) @(posedge CLK);
  endtask

  task automatic wait_done(input int nwr, input int nrd, input int nalu, input int ntx);
    int t = 0;
    while ((wr_q.size() < nwr || rd_q.size() < nrd || alu_q.size() < nalu ||
            tx_q.size() < ntx || TX_BUSY) && t < 400) begin
      @(posedge CLK);
      t++;
    end
    if (t >= 400) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: wr=%0d rd=%0d alu=%0d tx=%0d, expected %0d %0d %0d %0d",
               wr_q.size(), rd_q.size(), alu_q.size(), tx_q.size(), nwr, nrd, nalu, ntx);
    end
    repeat (4) @(posedge CLK);
  endtask

  task automatic compare(input string tag, input int nwr, input logic [23:0] wr, input int nrd,
                         input logic [3:0] ra, input int nalu, input logic [3:0] fun,
                         input int ntx, input logic [15:0] tx, input int busy);
    logic [11:0] ew[2];
    logic [7:0]  et[2];
    ew[0] = wr[23:12]; ew[1] = wr[11:0];
    et[0] = tx[15:8];  et[1] = tx[7:0];
    check({tag, ".nwr"}, wr_q.size(), nwr);
    for (int i = 0; i < nwr && i < wr_q.size(); i++)
      check($sformatf("%s.wr%0d", tag, i), wr_q[i], ew[i]);
    check({tag, ".nrd"}, rd_q.size(), nrd);
    if (nrd > 0 && rd_q.size() > 0) check({tag, ".rd_addr"}, rd_q[0], ra);
    check({tag, ".nalu"}, alu_q.size(), nalu);
    if (nalu > 0 && alu_q.size() > 0) check({tag, ".alu_fun"}, alu_q[0], fun);
    check({tag, ".ntx"}, tx_q.size(), ntx);
    for (int i = 0; i < ntx && i < tx_q.size(); i++)
      check($sformatf("%s.tx%0d", tag, i), tx_q[i], et[i]);
    if (tx_cyc_q.size() == 2)
      check({tag, ".tx_gap"}, (tx_cyc_q[1] - tx_cyc_q[0]) > busy, 1);
  endtask

  task automatic run_frame(input string tag, input logic [31:0] b, input logic [7:0] rd,
                           input logic [15:0] alu, input int busy, input int gap,
                           input int nwr, input logic [23:0] wr, input int nrd, input logic [3:0] ra,
                           input int nalu, input logic [3:0] fun, input int ntx, input logic [15:0] tx);
    int n;
    n = frame_len(b[31:24]);
    rd_val = rd; alu_val = alu; busy_len = busy;
    clear_q();
    for (int k = 0; k < n; k++) send_byte(b[31-8*k -: 8], gap);
    wait_done(nwr, nrd, nalu, ntx);
    compare(tag, nwr, wr, nrd, ra, nalu, fun, ntx, tx, busy);
  endtask

  typedef struct packed {
    logic [31:0] bytes;
    logic [7:0]  rd;
    logic [15:0] alu;
    logic [7:0]  busy;
    logic [1:0]  nwr;
    logic [23:0] wr;
    logic        nrd;
    logic [3:0]  ra;
    logic        nalu;
    logic [3:0]  fun;
    logic [1:0]  ntx;
    logic [15:0] tx;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int          nwr, nrd, nalu, ntx;
    logic [23:0] wr;
    logic [3:0]  ra, fun;
    logic [15:0] tx;
    logic [31:0] b;
    logic [7:0]  op;

    vecs[0] = '{32'hAA053C00, 8'h00, 16'h0000, 8'd3,  2'd1, 24'h53C000, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0, 16'h0000};
    vecs[1] = '{32'hBB050000, 8'h3C, 16'h0000, 8'd3,  2'd0, 24'h000000, 1'b1, 4'h5, 1'b0, 4'h0, 2'd1, 16'h3C00};
    vecs[2] = '{32'hCC0A0300, 8'h00, 16'h000D, 8'd3,  2'd2, 24'h00A103, 1'b0, 4'h0, 1'b1, 4'h0, 2'd2, 16'h0D00};
    vecs[3] = '{32'hDD020000, 8'h00, 16'h1234, 8'd20, 2'd0, 24'h000000, 1'b0, 4'h0, 1'b1, 4'h2, 2'd2, 16'h3412};
    vecs[4] = '{32'h55000000, 8'h00, 16'h0000, 8'd3,  2'd0, 24'h000000, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0, 16'h0000};
    vecs[5] = '{32'hAA01FF00, 8'h00, 16'h0000, 8'd3,  2'd1, 24'h1FF000, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0, 16'h0000};
    vecs[6] = '{32'hBBF30000, 8'hA5, 16'h0000, 8'd3,  2'd0, 24'h000000, 1'b1, 4'h3, 1'b0, 4'h0, 2'd1, 16'hA500};
    vecs[7] = '{32'hDD7F0000, 8'h00, 16'hFFFE, 8'd1,  2'd0, 24'h000000, 1'b0, 4'h0, 1'b1, 4'hF, 2'd2, 16'hFEFF};

    RST = 1'b0; RX_D_VLD = 1'b0; RX_P_DATA = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_outputs", {Address, WrEn, RdEn, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD}, 0);
    @(posedge CLK); #2;
    RST = 1'b1;

    for (int i = 0; i < 8; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].bytes, vecs[i].rd, vecs[i].alu, int'(vecs[i].busy), 1,
                int'(vecs[i].nwr), vecs[i].wr, int'(vecs[i].nrd), vecs[i].ra,
                int'(vecs[i].nalu), vecs[i].fun, int'(vecs[i].ntx), vecs[i].tx);

    // A byte arriving while the ALU result is pending must vanish
    alu_lat = 8; alu_val = 16'hBEEF; busy_len = 2;
    clear_q();
    send_byte(8'hDD, 0);
    send_byte(8'h04, 0);
    send_byte(8'hAA, 0);
    wait_done(0, 0, 1, 2);
    compare("drop_in_alu_wait", 0, 24'h0, 0, 4'h0, 1, 4'h4, 2, 16'hEFBE, 2);
    alu_lat = 2;
    run_frame("read_after_drop", 32'hBB020000, 8'h77, 16'h0, 2, 0,
              0, 24'h0, 1, 4'h2, 0, 4'h0, 1, 16'h7700);

    // Reset in the middle of a write frame
    run_frame("pre_reset_write", 32'hAA0C5A00, 8'h00, 16'h0, 2, 0,
              1, 24'hC5A000, 0, 4'h0, 0, 4'h0, 0, 16'h0);
    clear_q();
    send_byte(8'hAA, 0);
    send_byte(8'h07, 0);
    @(posedge CLK); #3;
    RST = 1'b0;
    #1;
    check("async_reset_outputs", {Address, WrEn, RdEn, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD}, 0);
    repeat (2) @(posedge CLK); #2;
    RST = 1'b1;
    send_byte(8'h99, 0);
    repeat (10) @(posedge CLK);
    check("post_reset_nwr", wr_q.size(), 0);
    check("post_reset_nevents", rd_q.size() + alu_q.size() + tx_q.size(), 0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: op = 8'hAA;
        1: op = 8'hBB;
        2: op = 8'hCC;
        3: op = 8'hDD;
        default: begin
          op = 8'($urandom_range(0, 255));
          while (op == 8'hAA || op == 8'hBB || op == 8'hCC || op == 8'hDD) op = 8'($urandom_range(0, 255));
        end
      endcase
      b = {op, 24'($urandom())};
      rd_val  = 8'($urandom());
      alu_val = 16'($urandom());
      alu_lat = $urandom_range(1, 5);
      model(b, rd_val, alu_val, nwr, wr, nrd, ra, nalu, fun, ntx, tx);
      run_frame($sformatf("rand%0d", i), b, rd_val, alu_val, $urandom_range(1, 8), $urandom_range(0, 3),
                nwr, wr, nrd, ra, nalu, fun, ntx, tx);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sys_ctrl.md
# sys_ctrl

Command controller between the UART receiver and the register file / ALU. Parses byte frames from the RX deframer, issues register writes and reads, launches ALU operations, and returns read data and ALU results to the UART transmitter one byte at a time. Single clock domain; the register file and ALU sit directly downstream, the UART RX/TX directly up and down.

## Interface
- DATA_WIDTH, 8: byte width of RX/TX and register data.
- ADDRESS_WIDTH, 4: register file address width.
- ALU_OUT_WIDTH, 16: ALU result width; must equal 2*DATA_WIDTH.
- CLK  in  1  system clock.
- RST  in  1  reset, asynchronous, active-low.
- RX_P_DATA  in  DATA_WIDTH  received byte.
- RX_D_VLD  in  1  one-cycle pulse, RX_P_DATA valid.
- RdData  in  DATA_WIDTH  register file read data.
- RdData_valid  in  1  register file read data valid.
- ALU_OUT  in  ALU_OUT_WIDTH  ALU result.
- ALU_OUT_VLD  in  1  ALU result valid.
- TX_BUSY  in  1  transmitter busy.
- Address  out  ADDRESS_WIDTH  register address.
- WrEn  out  1  register write strobe.
- RdEn  out  1  register read strobe.
- WrData  out  DATA_WIDTH  register write data.
- ALU_EN  out  1  ALU start strobe.
- ALU_FUN  out  4  ALU function code.
- CLK_EN  out  1  ALU clock-gate enable.
- TX_P_DATA  out  DATA_WIDTH  byte to transmit.
- TX_D_VLD  out  1  one-cycle pulse, TX_P_DATA valid.

## Operation
- Opcodes (first byte of a frame): 0xAA write (addr, data); 0xBB read (addr); 0xCC ALU with operands (A, B, fun); 0xDD ALU without operands (fun). Any other first byte is dropped; stay IDLE.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_SEND, TX_GAP, TX_SEND_HI.
- Frame bytes are consumed only on RX_D_VLD; a state with no pulse holds indefinitely.
- Write: address byte latched (low ADDRESS_WIDTH bits); on data byte, WrEn=1, Address, WrData=byte for exactly one cycle; return to IDLE.
- Read: on address byte, RdEn=1 one cycle → RD_WAIT; on RdData_valid, latch RdData as tx byte → TX_SEND; after send, IDLE.
- ALU 0xCC: byte A written to address 0, byte B to address 1, each as a one-cycle WrEn; then fun byte → path of 0xDD.
- ALU fun: ALU_FUN=byte[3:0], ALU_EN=1 one cycle, CLK_EN=1 from that cycle until ALU_OUT_VLD sampled; → ALU_WAIT. On ALU_OUT_VLD latch ALU_OUT; send low byte, then high byte; return IDLE.
- TX handshake: in TX_SEND/TX_SEND_HI, TX_D_VLD pulses one cycle with TX_P_DATA stable, only in a cycle where TX_BUSY=0. TX_GAP waits for TX_BUSY=1 (byte accepted) before TX_SEND_HI.
- RX_D_VLD during RD_WAIT, ALU_WAIT or any TX state: byte dropped, no state change.
- Strobes WrEn, RdEn, ALU_EN, TX_D_VLD never overlap.

## Timing
- Reset: state IDLE; all outputs 0; latched address, operands, result cleared.
- All outputs registered; strobes appear the cycle after the RX_D_VLD/valid that triggers them.
- Write latency: WrEn asserted 1 cycle after data-byte RX_D_VLD.
- Read: RdEn 1 cycle after address byte; TX_D_VLD no earlier than 1 cycle after RdData_valid.
- ALU: ALU_EN 1 cycle after fun byte; first TX_D_VLD ≥1 cycle after ALU_OUT_VLD; second only after TX_BUSY has risen and fallen.
- Address holds last value between strobes; WrData/TX_P_DATA hold last value.
- Reset mid-frame: immediate return to IDLE, partial frame discarded, no strobe emitted.

## Test plan
- Reset then frame AA,05,3C → exactly one cycle WrEn=1, Address=5, WrData=0x3C; no other strobe.
- Frame BB,05 with RdData=0x3C returned next cycle → RdEn one cycle, then one TX_D_VLD with TX_P_DATA=0x3C.
- Frame CC,0A,03,00 (add) with ALU_OUT=0x000D → writes addr0=0x0A, addr1=0x03, ALU_EN with ALU_FUN=0, TX bytes 0x0D then 0x00.
- Frame DD,02 with ALU_OUT=0x1234, TX_BUSY high 20 cycles after first byte → TX 0x34, no second TX_D_VLD while busy, then 0x12.
- Unknown byte 0x55, then AA,01,FF → 0x55 ignored, single write addr1=0xFF.
- RST asserted after AA,07 → all outputs 0 immediately; subsequent byte 0x99 produces no WrEn.
